// File: rtl/bouncing_sprite_engine.sv
// Bouncing-ball sprite: tick-driven position/direction, key-controlled speed and pause, RGB pixel.
// Optional BOUNCE_FLASH_EN: ball colour inverts for 16 ticks after each bounce.
module bouncing_sprite_engine #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned COORD_W   = 11,
  parameter int unsigned RADIUS    = 26,
  parameter int unsigned TICK_DIV  = 1258750,
  parameter int unsigned MAX_SPEED = 8,
  parameter logic [23:0] FG_RGB    = 24'h0000FF,
  parameter logic [23:0] BG_RGB    = 24'hC8FFC8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_key_up_n,
  input  logic               i_key_down_n,
  input  logic               i_key_pause_n,
  output logic [7:0]         o_r,
  output logic [7:0]         o_g,
  output logic [7:0]         o_b,
  output logic [COORD_W-1:0] o_cx,
  output logic [COORD_W-1:0] o_cy,
  output logic [3:0]         o_speed,
  output logic               o_paused,
  output logic               o_hit,
  output logic               o_hit_x,
  output logic               o_hit_y
);
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned S_W   = COORD_W + 1;
  localparam int unsigned P_W   = 2 * S_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [S_W-1:0]   X_MIN    = S_W'(RADIUS);
  localparam logic [S_W-1:0]   X_MAX    = S_W'(H_ACTIVE - 1 - RADIUS);
  localparam logic [S_W-1:0]   Y_MIN    = S_W'(RADIUS);
  localparam logic [S_W-1:0]   Y_MAX    = S_W'(V_ACTIVE - 1 - RADIUS);
  localparam logic [3:0]       SPD_MAX  = 4'(MAX_SPEED);
  localparam logic [P_W-1:0]   R2       = P_W'(RADIUS * RADIUS);

  // Returns {hit, moving_negative_next, new_position}; clamps to the wall on overshoot.
  function automatic logic [COORD_W+1:0] axis_step(input logic [COORD_W-1:0] pos,
      input logic neg, input logic [3:0] spd, input logic [S_W-1:0] lo,
      input logic [S_W-1:0] hi);
    logic [S_W-1:0] pe;
    logic [S_W-1:0] sp;
    pe = {1'b0, pos};
    sp = S_W'(spd);
    if (!neg) begin
      if (pe + sp >= hi) return {1'b1, 1'b1, COORD_W'(hi)};
      return {1'b0, 1'b0, COORD_W'(pe + sp)};
    end
    if (pe <= lo + sp) return {1'b1, 1'b0, COORD_W'(lo)};
    return {1'b0, 1'b1, COORD_W'(pe - sp)};
  endfunction

  // Key path: 2-flop synchroniser then falling-edge detector, bits {pause, down, up}.
  logic [2:0] sync1_q, sync2_q, prev_q, key_evt;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= {i_key_pause_n, i_key_down_n, i_key_up_n};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end
  assign key_evt = prev_q & ~sync2_q;

  logic [CNT_W-1:0] cnt_q;
  logic             tick;
  assign tick = (cnt_q == CNT_LAST);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
  end

  logic [3:0] speed_q, speed_d;
  always_comb begin
    speed_d = speed_q;
    if (key_evt[0] && !key_evt[1] && speed_q < SPD_MAX)    speed_d = speed_q + 4'd1;
    else if (key_evt[1] && !key_evt[0] && speed_q > 4'd1) speed_d = speed_q - 4'd1;
  end

  logic [COORD_W-1:0] cx_q, cy_q;
  logic               xneg_q, yneg_q, paused_q, hit_q, hit_x_q, hit_y_q;
  logic [COORD_W+1:0] x_nxt, y_nxt;
  logic               move;
  assign x_nxt = axis_step(cx_q, xneg_q, speed_q, X_MIN, X_MAX);
  assign y_nxt = axis_step(cy_q, yneg_q, speed_q, Y_MIN, Y_MAX);
  assign move  = tick & ~paused_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cx_q     <= COORD_W'(H_ACTIVE / 2);
      cy_q     <= COORD_W'(V_ACTIVE / 2);
      xneg_q   <= 1'b0;
      yneg_q   <= 1'b0;
      speed_q  <= 4'd1;
      paused_q <= 1'b0;
      hit_q    <= 1'b0;
      hit_x_q  <= 1'b0;
      hit_y_q  <= 1'b0;
    end else begin
      speed_q <= speed_d;
      if (key_evt[2]) paused_q <= ~paused_q;
      hit_x_q <= move & x_nxt[COORD_W+1];
      hit_y_q <= move & y_nxt[COORD_W+1];
      hit_q   <= move & (x_nxt[COORD_W+1] | y_nxt[COORD_W+1]);
      if (move) begin
        cx_q   <= x_nxt[COORD_W-1:0];
        xneg_q <= x_nxt[COORD_W];
        cy_q   <= y_nxt[COORD_W-1:0];
        yneg_q <= y_nxt[COORD_W];
      end
    end
  end

  logic [23:0] ball_rgb;
`ifdef BOUNCE_FLASH_EN
  logic [4:0] flash_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) flash_q <= '0;
    else if (move && (x_nxt[COORD_W+1] || y_nxt[COORD_W+1])) flash_q <= 5'd16;
    else if (tick && flash_q != '0) flash_q <= flash_q - 5'd1;
  end
  assign ball_rgb = (flash_q != '0) ? ~FG_RGB : FG_RGB;
`else
  assign ball_rgb = FG_RGB;
`endif

  // Sign-extended squares: the low P_W bits of the unsigned product equal the true square.
  logic [S_W-1:0] dx, dy;
  logic [P_W-1:0] dxe, dye, dist2;
  always_comb begin
    dx    = {1'b0, i_x} - {1'b0, cx_q};
    dy    = {1'b0, i_y} - {1'b0, cy_q};
    dxe   = {{S_W{dx[S_W-1]}}, dx};
    dye   = {{S_W{dy[S_W-1]}}, dy};
    dist2 = dxe * dxe + dye * dye;
  end

  logic [23:0] rgb_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rgb_q <= '0;
    else       rgb_q <= (dist2 < R2) ? ball_rgb : BG_RGB;
  end

  assign {o_r, o_g, o_b} = rgb_q;
  assign o_cx     = cx_q;
  assign o_cy     = cy_q;
  assign o_speed  = speed_q;
  assign o_paused = paused_q;
  assign o_hit    = hit_q;
  assign o_hit_x  = hit_x_q;
  assign o_hit_y  = hit_y_q;
endmodule

// File: tb/tb_bouncing_sprite_engine.sv
// Directed bench: 640x480 sprite for pixel/keys/pause/x-bounce, 480x480 sprite for a corner hit.
module tb_bouncing_sprite_engine;
  localparam int unsigned CW = 11;
  localparam int unsigned FG = 32'h0000FF;
  localparam int unsigned BG = 32'hC8FFC8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] x = '0;
  logic [CW-1:0] y = '0;
  logic          up_n = 1'b1, dn_n = 1'b1, pz_n = 1'b1;

  logic [7:0]    r, g, b, sr, sg, sb;
  logic [CW-1:0] cx, cy, scx, scy;
  logic [3:0]    speed, sspeed;
  logic          paused, hit, hit_x, hit_y, spaused, shit, shit_x, shit_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bouncing_sprite_engine #(.TICK_DIV(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y),
    .i_key_up_n(up_n), .i_key_down_n(dn_n), .i_key_pause_n(pz_n),
    .o_r(r), .o_g(g), .o_b(b), .o_cx(cx), .o_cy(cy), .o_speed(speed),
    .o_paused(paused), .o_hit(hit), .o_hit_x(hit_x), .o_hit_y(hit_y)
  );

  bouncing_sprite_engine #(.H_ACTIVE(480), .V_ACTIVE(480), .TICK_DIV(4)) sq (
    .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y),
    .i_key_up_n(1'b1), .i_key_down_n(1'b1), .i_key_pause_n(1'b1),
    .o_r(sr), .o_g(sg), .o_b(sb), .o_cx(scx), .o_cy(scy), .o_speed(sspeed),
    .o_paused(spaused), .o_hit(shit), .o_hit_x(shit_x), .o_hit_y(shit_y)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 4 clocks held, 4 released; the event lands 3 edges after the press starts.
  task automatic press(input logic u, input logic d, input logic p);
    up_n = ~u; dn_n = ~d; pz_n = ~p;
    step(4);
    up_n = 1'b1; dn_n = 1'b1; pz_n = 1'b1;
    step(4);
  endtask

  initial begin
    step(3);
    chk("rst_cx", 32'(cx), 320);
    chk("rst_cy", 32'(cy), 240);
    chk("rst_speed", 32'(speed), 1);
    chk("rst_paused", 32'(paused), 0);
    chk("rst_rgb", 32'({r, g, b}), 0);
    chk("rst_hit", 32'({hit, hit_x, hit_y}), 0);
    rst = 1'b0;                               // ticks now land on edges 4, 8, 12, ...

    x = 346; y = 240; step(1);
    chk("pix_dx26_bg", 32'({r, g, b}), BG);
    x = 345; step(1);
    chk("pix_dx25_fg", 32'({r, g, b}), FG);
    x = 320; step(1);
    chk("pix_centre_fg", 32'({r, g, b}), FG);
    chk("pre_tick_cx", 32'(cx), 320);
    x = 0; y = 0; step(1);                    // edge 4: first tick
    chk("pix_origin_bg", 32'({r, g, b}), BG);
    chk("tick1_cx", 32'(cx), 321);
    chk("tick1_cy", 32'(cy), 241);
    chk("tick1_hit", 32'(hit), 0);

    press(1'b0, 1'b0, 1'b1);                  // edge 12
    chk("pause_on", 32'(paused), 1);
    step(20);                                 // five ignored ticks
    chk("frozen_cx", 32'(cx), 321);
    chk("frozen_cy", 32'(cy), 241);

    repeat (10) press(1'b1, 1'b0, 1'b0);
    chk("speed_sat_hi", 32'(speed), 8);
    repeat (10) press(1'b0, 1'b1, 1'b0);
    chk("speed_sat_lo", 32'(speed), 1);
    repeat (2) press(1'b1, 1'b0, 1'b0);
    chk("speed_3", 32'(speed), 3);
    press(1'b1, 1'b1, 1'b0);
    chk("speed_cancel", 32'(speed), 3);
    chk("still_frozen_cx", 32'(cx), 321);
    repeat (5) press(1'b1, 1'b0, 1'b0);       // speed 8, edge 256

    press(1'b0, 1'b0, 1'b1);                  // unpause; two ticks at speed 8
    chk("pause_off", 32'(paused), 0);
    chk("resume_cx", 32'(cx), 337);
    chk("resume_cy", 32'(cy), 257);
    step(96);                                 // 26 moving ticks total
    chk("t26_cx", 32'(cx), 529);
    chk("t26_cy", 32'(cy), 449);
    step(4);                                  // tick 27: y clamps at 453
    chk("yhit_cy", 32'(cy), 453);
    chk("yhit_cx", 32'(cx), 537);
    chk("yhit_pulses", 32'({hit, hit_x, hit_y}), 32'b101);
    step(1);
    chk("yhit_clear", 32'({hit, hit_x, hit_y}), 0);
    step(27);                                 // tick 34
    chk("t34_cx", 32'(cx), 593);
    chk("t34_cy", 32'(cy), 397);

    press(1'b0, 1'b0, 1'b1);
    repeat (5) press(1'b0, 1'b1, 1'b0);
    chk("speed_back_3", 32'(speed), 3);
    chk("t34_hold_cx", 32'(cx), 593);
    press(1'b0, 1'b0, 1'b1);                  // ticks 35, 36
    chk("t36_cx", 32'(cx), 599);
    step(16);                                 // tick 40
    chk("t40_cx", 32'(cx), 611);
    chk("t40_cy", 32'(cy), 379);
    step(4);                                  // tick 41: x clamps at 613
    chk("xhit_cx", 32'(cx), 613);
    chk("xhit_cy", 32'(cy), 376);
    chk("xhit_pulses", 32'({hit, hit_x, hit_y}), 32'b110);
    step(1);
    chk("xhit_clear", 32'({hit, hit_x, hit_y}), 0);
    step(3);                                  // tick 42, moving -x
    chk("xback_cx", 32'(cx), 610);
    chk("xback_cy", 32'(cy), 373);

    step(379);                                // edge 851: square sprite one tick from corner
    chk("sq_pre_cx", 32'(scx), 452);
    chk("sq_pre_cy", 32'(scy), 452);
    chk("sq_pre_hit", 32'({shit, shit_x, shit_y}), 0);
    step(1);
    chk("sq_corner_pos", 32'({scx, scy}), 32'({11'd453, 11'd453}));
    chk("sq_corner_hits", 32'({shit, shit_x, shit_y}), 32'b111);
    step(1);
    chk("sq_corner_clear", 32'({shit, shit_x, shit_y}), 0);
    step(3);
    chk("sq_flip_pos", 32'({scx, scy}), 32'({11'd452, 11'd452}));

    press(1'b0, 1'b0, 1'b1);
    chk("pause_again", 32'(paused), 1);
    step(2);                                  // counter mid-period
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_cx", 32'(cx), 320);
    chk("async_cy", 32'(cy), 240);
    chk("async_speed", 32'(speed), 1);
    chk("async_paused", 32'(paused), 0);
    chk("async_rgb", 32'({r, g, b}), 0);
    chk("async_hit", 32'({hit, hit_x, hit_y}), 0);
    step(1);
    rst = 1'b0;
    step(3);
    chk("rerun_no_tick", 32'(cx), 320);
    step(1);
    chk("rerun_tick_cx", 32'(cx), 321);
    chk("rerun_tick_cy", 32'(cy), 241);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
